// File: rtl/persiana_pkg.sv
// Shared types and helpers for the multi-level blind controller.
package persiana_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    SUBIENDO = 2'd1,
    BAJANDO  = 2'd2,
    PAUSA    = 2'd3
  } estado_e;

  function automatic int pos_width(input int niveles);
    return (niveles > 2) ? $clog2(niveles) : 1;
  endfunction

  function automatic int pos_medio(input int niveles);
    return (niveles - 1) / 2;
  endfunction

endpackage

// File: rtl/persiana_multinivel_if.sv
// Command/sensor inputs and motor/position outputs of the blind controller.
interface persiana_multinivel_if
  import persiana_pkg::*;
#(
  parameter int NIVELES = 4,
  parameter int SW      = 8
);
  localparam int PW = pos_width(NIVELES);

  logic          ab;
  logic          me;
  logic          ba;
  logic          auto;
  logic [SW-1:0] luz;
  logic [PW-1:0] pos;
  logic          motor_sube;
  logic          motor_baja;
  logic          ocupado;

  modport master (
    output ab, me, ba, auto, luz,
    input  pos, motor_sube, motor_baja, ocupado
  );

  modport slave (
    input  ab, me, ba, auto, luz,
    output pos, motor_sube, motor_baja, ocupado
  );
endinterface

// File: rtl/persiana_temporizador.sv
// Loadable up/down counter with synchronous clear and terminal-count flag.
module persiana_temporizador #(
  parameter int W = 3
) (
  input  logic         reloj,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_valor,
  input  logic         i_en,
  input  logic         i_sube,
  input  logic [W-1:0] i_limite,
  output logic         o_tc
);
  logic [W-1:0] r_cuenta;

  // NOTE: reset is synchronous and active-low, so it lives inside the clocked block.
  always_ff @(posedge reloj) begin
    if (!reset)      r_cuenta <= '0;
    else if (i_clr)  r_cuenta <= '0;
    else if (i_load) r_cuenta <= i_valor;
    else if (i_en)   r_cuenta <= i_sube ? r_cuenta + W'(1) : r_cuenta - W'(1);
  end

  // Counting up ends at the limit; counting down ends at zero.
  assign o_tc = i_sube ? (r_cuenta == i_limite) : (r_cuenta == '0);
endmodule

// File: rtl/persiana_multinivel.sv
// Multi-level blind controller: ab/me/ba targets, per-level travel time, reversal dead time.
// Macro PERSIANA_AUTO_EN enables the light-sensor auto mode; otherwise auto/luz are ignored.
module persiana_multinivel
  import persiana_pkg::*;
#(
  parameter int NIVELES     = 4,
  parameter int STEP_CYCLES = 5,
  parameter int DEAD_CYCLES = 2,
  parameter int SW          = 8,
  parameter int UMBRAL_BAJO = 40,
  parameter int UMBRAL_ALTO = 200
) (
  input logic                  reloj,
  input logic                  reset,
  persiana_multinivel_if.slave bus
);
  localparam int PW    = pos_width(NIVELES);
  localparam int T_MAX = (STEP_CYCLES > DEAD_CYCLES) ? STEP_CYCLES : DEAD_CYCLES;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam logic [PW-1:0] POS_MAX = PW'(NIVELES - 1);
  localparam logic [PW-1:0] POS_MID = PW'(pos_medio(NIVELES));

  estado_e       r_estado, w_estado_next;
  logic [PW-1:0] r_pos, w_pos_next;
  logic [PW-1:0] r_objetivo, w_objetivo_next;
  logic          r_motor_sube, r_motor_baja, r_ocupado;
  logic          w_paso_clr, w_paso_en, w_paso_tc;
  logic          w_pausa_load, w_pausa_en, w_pausa_tc;
  logic          w_auto_valido;
  logic [PW-1:0] w_auto_objetivo;

`ifdef PERSIANA_AUTO_EN
  // Between the thresholds auto mode is not valid, so objetivo simply holds.
  assign w_auto_valido   = bus.auto && (r_estado == REPOSO) &&
                           ((bus.luz <= SW'(UMBRAL_BAJO)) || (bus.luz >= SW'(UMBRAL_ALTO)));
  assign w_auto_objetivo = (bus.luz <= SW'(UMBRAL_BAJO)) ? POS_MAX : POS_MID;
`else
  logic w_unused_auto;
  assign w_unused_auto   = ^{bus.auto, bus.luz, SW'(UMBRAL_BAJO), SW'(UMBRAL_ALTO)};
  assign w_auto_valido   = 1'b0;
  assign w_auto_objetivo = '0;
`endif

  always_comb begin
    w_objetivo_next = r_objetivo;
    if (bus.ab)             w_objetivo_next = POS_MAX;
    else if (bus.me)        w_objetivo_next = POS_MID;
    else if (bus.ba)        w_objetivo_next = '0;
    else if (w_auto_valido) w_objetivo_next = w_auto_objetivo;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    w_estado_next = r_estado;
    w_pos_next    = r_pos;
    w_paso_clr    = 1'b0;
    w_paso_en     = 1'b0;
    w_pausa_load  = 1'b0;
    w_pausa_en    = 1'b0;
    case (r_estado)
      REPOSO: begin
        w_paso_clr = 1'b1;
        if (r_objetivo > r_pos)      w_estado_next = SUBIENDO;
        else if (r_objetivo < r_pos) w_estado_next = BAJANDO;
      end
      SUBIENDO: begin
        if (r_objetivo <= r_pos) begin
          w_estado_next = PAUSA;
          w_paso_clr    = 1'b1;
          w_pausa_load  = 1'b1;
        end else if (w_paso_tc) begin
          w_paso_clr = 1'b1;
          w_pos_next = (r_pos == POS_MAX) ? r_pos : r_pos + PW'(1);
          if (w_pos_next == r_objetivo) w_estado_next = REPOSO;
        end else begin
          w_paso_en = 1'b1;
        end
      end
      BAJANDO: begin
        if (r_objetivo >= r_pos) begin
          w_estado_next = PAUSA;
          w_paso_clr    = 1'b1;
          w_pausa_load  = 1'b1;
        end else if (w_paso_tc) begin
          w_paso_clr = 1'b1;
          w_pos_next = (r_pos == '0) ? r_pos : r_pos - PW'(1);
          if (w_pos_next == r_objetivo) w_estado_next = REPOSO;
        end else begin
          w_paso_en = 1'b1;
        end
      end
      PAUSA: begin
        w_pausa_en = !w_pausa_tc;
        if (w_pausa_tc) begin
          if (r_objetivo > r_pos)      w_estado_next = SUBIENDO;
          else if (r_objetivo < r_pos) w_estado_next = BAJANDO;
          else                         w_estado_next = REPOSO;
        end
      end
      default: w_estado_next = REPOSO;
    endcase
  end

  persiana_temporizador #(.W(TW)) u_paso (
    .reloj    (reloj),
    .reset    (reset),
    .i_clr    (w_paso_clr),
    .i_load   (1'b0),
    .i_valor  ('0),
    .i_en     (w_paso_en),
    .i_sube   (1'b1),
    .i_limite (TW'(STEP_CYCLES - 1)),
    .o_tc     (w_paso_tc)
  );

  // Dead time counts down from DEAD_CYCLES-1, loaded on the edge that enters PAUSA.
  persiana_temporizador #(.W(TW)) u_pausa (
    .reloj    (reloj),
    .reset    (reset),
    .i_clr    (1'b0),
    .i_load   (w_pausa_load),
    .i_valor  (TW'(DEAD_CYCLES - 1)),
    .i_en     (w_pausa_en),
    .i_sube   (1'b0),
    .i_limite ('0),
    .o_tc     (w_pausa_tc)
  );

  // NOTE: state and outputs use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge reloj) begin
    if (!reset) begin
      r_estado     <= REPOSO;
      r_pos        <= '0;
      r_objetivo   <= '0;
      r_motor_sube <= 1'b0;
      r_motor_baja <= 1'b0;
      r_ocupado    <= 1'b0;
    end else begin
      r_estado     <= w_estado_next;
      r_pos        <= w_pos_next;
      r_objetivo   <= w_objetivo_next;
      r_motor_sube <= (w_estado_next == SUBIENDO);
      r_motor_baja <= (w_estado_next == BAJANDO);
      r_ocupado    <= (w_estado_next != REPOSO);
    end
  end

  assign bus.pos        = r_pos;
  assign bus.motor_sube = r_motor_sube;
  assign bus.motor_baja = r_motor_baja;
  assign bus.ocupado    = r_ocupado;
endmodule

// File: doc/persiana_multinivel.md
# persiana_multinivel

Parametrised successor to the three-position blind controller: drives a blind motor across NIVELES discrete positions instead of jumping between fixed codes. Handles manual commands, an optional light-sensor automatic mode with hysteresis, per-level travel time, and a motor-off dead time on direction reversal. Sits between the push-button/sensor front end and the motor driver; `pos` feeds the position display.

## Interface
- NIVELES, 4: number of positions, ≥3. Position 0 = closed, NIVELES-1 = open, middle = (NIVELES-1)/2 (integer division).
- STEP_CYCLES, 5: motor-on cycles per one-level move, ≥2.
- DEAD_CYCLES, 2: motor-off cycles on direction reversal, ≥1.
- SW, 8: light sensor width.
- UMBRAL_BAJO, 40: at or below this light value, auto mode targets open.
- UMBRAL_ALTO, 200: at or above this light value, auto mode targets middle. Must be > UMBRAL_BAJO.
- reloj  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- ab  in  1  open command, one-cycle pulse; target = NIVELES-1.
- me  in  1  middle command, pulse; target = middle.
- ba  in  1  close command, pulse; target = 0.
- auto  in  1  level; enables automatic mode.
- luz  in  SW  light sensor value, unsigned.
- pos  out  $clog2(NIVELES)  current position.
- motor_sube  out  1  motor up drive.
- motor_baja  out  1  motor down drive; never high together with motor_sube.
- ocupado  out  1  high whenever state ≠ REPOSO.

## Operation
- FSM states: REPOSO, SUBIENDO, BAJANDO, PAUSA.
- Command priority: ab > me > ba. Manual commands are accepted in every state and overwrite `objetivo`.
- Auto mode is evaluated only in REPOSO, only when no manual command is present in that cycle:
  - luz ≤ UMBRAL_BAJO → objetivo = NIVELES-1.
  - luz ≥ UMBRAL_ALTO → objetivo = middle.
  - otherwise → hold the current objetivo.
- REPOSO: if objetivo > pos, go to SUBIENDO. If objetivo < pos, go to BAJANDO. If equal, no action.
- SUBIENDO / BAJANDO: step timer counts 0..STEP_CYCLES-1. At terminal count, pos moves ±1 and the timer clears.
  - If the new pos equals objetivo, return to REPOSO on the same edge.
  - Same-direction retarget: keep the timer running.
- Reversal: a new objetivo at or behind pos, relative to the current direction, triggers PAUSA.
  - PAUSA lasts DEAD_CYCLES cycles with both motors off. The partial step is discarded (pos unchanged, timer cleared).
  - After PAUSA: go to the opposite direction if objetivo ≠ pos, else REPOSO.
  - A command that arrives during PAUSA updates objetivo. The PAUSA count is not restarted.
- pos saturates at 0 and NIVELES-1. No wrap-around.

## Timing
- All outputs are registered. The motor asserts on the first edge after the command is sampled.
- One level takes exactly STEP_CYCLES motor-on cycles. pos updates on the edge where the motor drops or continues.
- Reset (reset=0 at an edge): pos=0, objetivo=0, state REPOSO, timers 0, motor_sube=0, motor_baja=0, ocupado=0.
  - Applies mid-motion too. No position memory survives reset.

## Configuration
- PERSIANA_AUTO_EN defined: auto mode as described above.
- PERSIANA_AUTO_EN undefined: `auto` and `luz` are ignored, so only ab/me/ba move the blind. Ports remain present.

## Structure
- Package persiana_pkg holds:
  - the FSM state encoding (REPOSO=2'd0, SUBIENDO=2'd1, BAJANDO=2'd2, PAUSA=2'd3);
  - helper functions for the middle position and pos width.
- Sub-module persiana_temporizador: a loadable down/up counter with clear and terminal-count flag. It is reused for both the step timer and the PAUSA dead-time timer.

## Test plan
(All scenarios use the defaults.)
- Reset, then an ab pulse:
  - motor_sube is high for 15 cycles;
  - pos goes 1, 2, 3 at motor cycles 5, 10, 15;
  - then ocupado=0.
- From pos=3, a me pulse: motor_baja is high for 10 cycles and pos ends at 1.
- From pos=0, ab pulse, then a ba pulse at motor cycle 7 (pos=1):
  - motors are off for 2 cycles;
  - then motor_baja runs for 5 cycles and pos ends at 0.
- ab and ba in the same cycle: the blind opens to 3. A me pulse during SUBIENDO from pos 0 stops the motion at pos 1.
- auto=1 with PERSIANA_AUTO_EN defined:
  - luz=30 → moves to 3;
  - luz=100 → holds;
  - luz=220 → moves to 1.
  - Same sequence without the macro → no motion.
- reset=0 held for one edge during BAJANDO: on the next edge all outputs are 0 and pos=0. After release, the next ab pulse takes 15 cycles to reach pos 3.
